// File: rtl/mc_ahb_csr_bank.sv
// AHB-Lite zero-wait-state CSR bank holding the LPDDR4 controller timing/config registers.
// Optional feature macro: MC_CSR_ERRRESP_EN (two-cycle ERROR response for unmapped accesses).
module mc_ahb_csr_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter logic [31:0] ID_VALUE  = 32'h4D43_0100
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic [31:0] i_haddr,
  input  logic        i_hwrite,
  input  logic        i_hsel,
  input  logic        i_hreadyin,
  input  logic [31:0] i_hwdata,
  input  logic [1:0]  i_htrans,
  input  logic [2:0]  i_hsize,
  input  logic [2:0]  i_hburst,
  output logic        o_hready,
  output logic [31:0] o_hrdata,
  output logic [1:0]  o_hresp,
  output logic        o_hgrant,
  output logic [1:0]  o_mul_rdphase_cfg,
  output logic [1:0]  o_mul_wrphase_cfg,
  output logic [1:0]  o_mul_rdcmd_phase_cfg,
  output logic [1:0]  o_mul_wrcmd_phase_cfg,
  output logic [7:0]  o_mul_tRRD_cfg,
  output logic [7:0]  o_mul_tFAW_cfg,
  output logic [7:0]  o_mul_tCCD_cfg,
  output logic [7:0]  o_mul_WTR_LATENCY_cfg,
  output logic [7:0]  o_mul_RTW_LATENCY_cfg,
  output logic [7:0]  o_mul_READ_TIME_cfg,
  output logic [7:0]  o_mul_WRITE_TIME_cfg,
  output logic [11:0] o_ref_tREFI_cfg,
  output logic [3:0]  o_ref_POSTPONE_cfg,
  output logic [7:0]  o_ref_tRP_cfg,
  output logic [7:0]  o_ref_tRFC_cfg,
  output logic [7:0]  o_bm_tRTP_cfg,
  output logic [7:0]  o_bm_tWTP_cfg,
  output logic [7:0]  o_bm_tRAS_cfg,
  output logic [7:0]  o_bm_tRC_cfg,
  output logic [7:0]  o_bm_tRP_cfg,
  output logic [7:0]  o_bm_tRCD_cfg,
  output logic [7:0]  o_bm_tCCDMW_cfg,
  output logic [7:0]  o_crb_READ_LATENCY_cfg,
  output logic [7:0]  o_crb_WRITE_LATENCY_cfg
);

  localparam int NREG = 6;

  function automatic logic [31:0] rst_val(input logic [2:0] idx);
    case (idx)
      3'd0:    rst_val = 32'h0410_0400;
      3'd1:    rst_val = 32'h2020_0808;
      3'd2:    rst_val = 32'h2C06_8618;
      3'd3:    rst_val = 32'h140E_0C04;
      3'd4:    rst_val = 32'h0010_0606;
      3'd5:    rst_val = 32'h0000_080E;
      default: rst_val = 32'h0000_0000;
    endcase
  endfunction

  // Reserved bits of BM1 and CRB are never stored so they always read as zero.
  function automatic logic [31:0] wr_mask(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: wr_mask = 32'hFFFF_FFFF;
      3'd4:    wr_mask = 32'h00FF_FFFF;
      3'd5:    wr_mask = 32'h0000_FFFF;
      default: wr_mask = 32'h0000_0000;
    endcase
  endfunction

  logic [31:0] csr_q [NREG];
  logic [31:0] csr_d [NREG];
  logic        wr_pend_q, wr_pend_d;
  logic [2:0]  wr_idx_q, wr_idx_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hready_q, hready_d;
  logic [1:0]  hresp_q, hresp_d;
  logic        err1_q, err1_d;
  logic        grant_q, grant_d;

  logic        in_win_s;
  logic [5:0]  idx_s;
  logic        writable_s;
  logic        id_hit_s;
  logic        accept_s;
  logic [31:0] rd_val_s;
  logic        unused_ok_s;

  assign unused_ok_s = ^{i_hsize, i_hburst, i_htrans[0], i_haddr[1:0]};

  assign in_win_s   = (i_haddr[31:8] == BASE_ADDR[31:8]);
  assign idx_s      = i_haddr[7:2];
  assign writable_s = in_win_s && (idx_s < 6'd6);
  assign id_hit_s   = in_win_s && (idx_s == 6'd6);
  assign accept_s   = i_hsel & i_hreadyin & i_htrans[1] & hready_q;

  // Read source: the previous data phase's write commits on this same edge, so forward it.
  always_comb begin
    rd_val_s = 32'h0000_0000;
    if (id_hit_s) begin
      rd_val_s = ID_VALUE;
    end else if (writable_s) begin
      for (int i = 0; i < NREG; i++) begin
        if (idx_s[2:0] == 3'(i)) begin
          if (wr_pend_q && (wr_idx_q == 3'(i))) begin
            rd_val_s = i_hwdata & wr_mask(3'(i));
          end else begin
            rd_val_s = csr_q[i];
          end
        end else begin
          rd_val_s = rd_val_s;
        end
      end
    end else begin
      rd_val_s = 32'h0000_0000;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      csr_d[i] = csr_q[i];
      if (wr_pend_q && (wr_idx_q == 3'(i))) begin
        csr_d[i] = i_hwdata & wr_mask(3'(i));
      end else begin
        csr_d[i] = csr_q[i];
      end
    end
    wr_pend_d = accept_s & i_hwrite & writable_s;
    wr_idx_d  = idx_s[2:0];
    rdata_d   = (accept_s && !i_hwrite) ? rd_val_s : 32'h0000_0000;
`ifdef MC_CSR_ERRRESP_EN
    err1_d    = accept_s & ~(writable_s | id_hit_s);
`else
    err1_d    = 1'b0;
`endif
    // ERROR spans two cycles: stalled first cycle, then the completing cycle.
    hready_d  = ~err1_d;
    hresp_d   = {1'b0, err1_d | err1_q};
    grant_d   = 1'b1;
  end

  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      for (int i = 0; i < NREG; i++) begin
        csr_q[i] <= rst_val(3'(i));
      end
      wr_pend_q <= 1'b0;
      wr_idx_q  <= 3'd0;
      rdata_q   <= 32'h0000_0000;
      hready_q  <= 1'b1;
      hresp_q   <= 2'b00;
      err1_q    <= 1'b0;
      grant_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        csr_q[i] <= csr_d[i];
      end
      wr_pend_q <= wr_pend_d;
      wr_idx_q  <= wr_idx_d;
      rdata_q   <= rdata_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      err1_q    <= err1_d;
      grant_q   <= grant_d;
    end
  end

  assign o_hready = hready_q;
  assign o_hrdata = rdata_q;
  assign o_hresp  = hresp_q;
  assign o_hgrant = grant_q;

  assign o_mul_rdphase_cfg       = csr_q[0][1:0];
  assign o_mul_wrphase_cfg       = csr_q[0][3:2];
  assign o_mul_rdcmd_phase_cfg   = csr_q[0][5:4];
  assign o_mul_wrcmd_phase_cfg   = csr_q[0][7:6];
  assign o_mul_tRRD_cfg          = csr_q[0][15:8];
  assign o_mul_tFAW_cfg          = csr_q[0][23:16];
  assign o_mul_tCCD_cfg          = csr_q[0][31:24];
  assign o_mul_WTR_LATENCY_cfg   = csr_q[1][7:0];
  assign o_mul_RTW_LATENCY_cfg   = csr_q[1][15:8];
  assign o_mul_READ_TIME_cfg     = csr_q[1][23:16];
  assign o_mul_WRITE_TIME_cfg    = csr_q[1][31:24];
  assign o_ref_tREFI_cfg         = csr_q[2][11:0];
  assign o_ref_POSTPONE_cfg      = csr_q[2][15:12];
  assign o_ref_tRP_cfg           = csr_q[2][23:16];
  assign o_ref_tRFC_cfg          = csr_q[2][31:24];
  assign o_bm_tRTP_cfg           = csr_q[3][7:0];
  assign o_bm_tWTP_cfg           = csr_q[3][15:8];
  assign o_bm_tRAS_cfg           = csr_q[3][23:16];
  assign o_bm_tRC_cfg            = csr_q[3][31:24];
  assign o_bm_tRP_cfg            = csr_q[4][7:0];
  assign o_bm_tRCD_cfg           = csr_q[4][15:8];
  assign o_bm_tCCDMW_cfg         = csr_q[4][23:16];
  assign o_crb_READ_LATENCY_cfg  = csr_q[5][7:0];
  assign o_crb_WRITE_LATENCY_cfg = csr_q[5][15:8];

endmodule

// File: tb/tb_mc_ahb_csr_bank.sv
// Directed table-driven bench for mc_ahb_csr_bank plus hand-written burst, forwarding,
// unmapped-access and mid-transfer reset sequences.
module tb_mc_ahb_csr_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] haddr, hwdata, hrdata;
  logic        hwrite, hsel, hreadyin, hready, hgrant;
  logic [1:0]  htrans, hresp;
  logic [2:0]  hsize, hburst;
  logic [1:0]  rdph, wrph, rdcph, wrcph;
  logic [7:0]  trrd, tfaw, tccd, wtr, rtw, rtime, wtime;
  logic [11:0] trefi;
  logic [3:0]  postpone;
  logic [7:0]  ref_trp, trfc, trtp, twtp, tras, trc, bm_trp, trcd, tccdmw, rl, wl;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_ahb_csr_bank dut (
    .i_sysclk(clk), .i_sysrst(rst), .i_haddr(haddr), .i_hwrite(hwrite), .i_hsel(hsel),
    .i_hreadyin(hreadyin), .i_hwdata(hwdata), .i_htrans(htrans), .i_hsize(hsize),
    .i_hburst(hburst), .o_hready(hready), .o_hrdata(hrdata), .o_hresp(hresp),
    .o_hgrant(hgrant),
    .o_mul_rdphase_cfg(rdph), .o_mul_wrphase_cfg(wrph), .o_mul_rdcmd_phase_cfg(rdcph),
    .o_mul_wrcmd_phase_cfg(wrcph), .o_mul_tRRD_cfg(trrd), .o_mul_tFAW_cfg(tfaw),
    .o_mul_tCCD_cfg(tccd), .o_mul_WTR_LATENCY_cfg(wtr), .o_mul_RTW_LATENCY_cfg(rtw),
    .o_mul_READ_TIME_cfg(rtime), .o_mul_WRITE_TIME_cfg(wtime),
    .o_ref_tREFI_cfg(trefi), .o_ref_POSTPONE_cfg(postpone), .o_ref_tRP_cfg(ref_trp),
    .o_ref_tRFC_cfg(trfc), .o_bm_tRTP_cfg(trtp), .o_bm_tWTP_cfg(twtp), .o_bm_tRAS_cfg(tras),
    .o_bm_tRC_cfg(trc), .o_bm_tRP_cfg(bm_trp), .o_bm_tRCD_cfg(trcd),
    .o_bm_tCCDMW_cfg(tccdmw), .o_crb_READ_LATENCY_cfg(rl), .o_crb_WRITE_LATENCY_cfg(wl)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Single transfer: address phase, then data phase with the bus idle; returns hrdata.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rd);
    haddr  = addr;
    hwrite = wr;
    htrans = 2'b10;
    hsel   = 1'b1;
    @(negedge clk);
    rd     = hrdata;
    htrans = 2'b00;
    hwrite = 1'b0;
    hwdata = wdata;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    vecs[0]  = '{32'h0200_0000, 1'b0, 32'h0, 32'h0410_0400, "rst_mul0"};
    vecs[1]  = '{32'h0200_0004, 1'b0, 32'h0, 32'h2020_0808, "rst_mul1"};
    vecs[2]  = '{32'h0200_0008, 1'b0, 32'h0, 32'h2C06_8618, "rst_ref"};
    vecs[3]  = '{32'h0200_000C, 1'b0, 32'h0, 32'h140E_0C04, "rst_bm0"};
    vecs[4]  = '{32'h0200_0010, 1'b0, 32'h0, 32'h0010_0606, "rst_bm1"};
    vecs[5]  = '{32'h0200_0014, 1'b0, 32'h0, 32'h0000_080E, "rst_crb"};
    vecs[6]  = '{32'h0200_0018, 1'b0, 32'h0, 32'h4D43_0100, "rd_id"};
    vecs[7]  = '{32'h0200_001C, 1'b0, 32'h0, 32'h0000_0000, "rd_unmapped_1c"};
    vecs[8]  = '{32'h0200_000C, 1'b1, 32'h1122_3344, 32'h0, "wr_bm0_rdata0"};
    vecs[9]  = '{32'h0200_000C, 1'b0, 32'h0, 32'h1122_3344, "rb_bm0"};
    vecs[10] = '{32'h0200_0018, 1'b1, 32'hDEAD_BEEF, 32'h0, "wr_id"};
    vecs[11] = '{32'h0200_0018, 1'b0, 32'h0, 32'h4D43_0100, "rb_id_ro"};
    vecs[12] = '{32'h0200_0014, 1'b1, 32'hFFFF_FFFF, 32'h0, "wr_crb_ones"};
    vecs[13] = '{32'h0200_0014, 1'b0, 32'h0, 32'h0000_FFFF, "rb_crb_mask"};
    vecs[14] = '{32'h0200_0010, 1'b1, 32'hFFFF_FFFF, 32'h0, "wr_bm1_ones"};
    vecs[15] = '{32'h0200_0010, 1'b0, 32'h0, 32'h00FF_FFFF, "rb_bm1_mask"};

    rst = 1'b1; haddr = 32'h0; hwdata = 32'h0; hwrite = 1'b0; hsel = 1'b0;
    hreadyin = 1'b1; htrans = 2'b00; hsize = 3'b010; hburst = 3'b000;
    repeat (3) @(negedge clk);
    chk("grant_in_reset", 32'(hgrant), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("grant_after_reset", 32'(hgrant), 32'h1);
    chk("hready_reset", 32'(hready), 32'h1);
    chk("hresp_reset", 32'(hresp), 32'h0);
    chk("hrdata_idle", hrdata, 32'h0);
    chk("rst_trefi", 32'(trefi), 32'h618);
    chk("rst_rl", 32'(rl), 32'h0E);

    for (int i = 0; i < 16; i++) begin
      xfer(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd);
      chk(vecs[i].name, rd, vecs[i].exp);
    end

    // INCR4 burst, no idle between beats
    hburst = 3'b011; hsel = 1'b1; hwrite = 1'b1;
    haddr = 32'h0200_0008; htrans = 2'b10; @(negedge clk);
    haddr = 32'h0200_000C; htrans = 2'b11; hwdata = 32'h001F_11FF; @(negedge clk);
    chk("burst_hready", 32'(hready), 32'h1);
    haddr = 32'h0200_0010; hwdata = 32'hBBBB_BBBB; @(negedge clk);
    haddr = 32'h0200_0014; hwdata = 32'hFFFF_FFFF; @(negedge clk);
    chk("burst_hresp", 32'(hresp), 32'h0);
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1234_5678; @(negedge clk);
    hburst = 3'b000;
    chk("burst_trefi", 32'(trefi), 32'h1FF);
    chk("burst_postpone", 32'(postpone), 32'h1);
    chk("burst_ref_trp", 32'(ref_trp), 32'h1F);
    chk("burst_trfc", 32'(trfc), 32'h00);
    chk("burst_bm0", {trc, tras, twtp, trtp}, 32'hBBBB_BBBB);
    chk("burst_bm1", {8'h00, tccdmw, trcd, bm_trp}, 32'h00FF_FFFF);
    chk("burst_rl", 32'(rl), 32'h78);
    chk("burst_wl", 32'(wl), 32'h56);
    xfer(32'h0200_0010, 1'b0, 32'h0, rd); chk("burst_rb_bm1", rd, 32'h00FF_FFFF);
    xfer(32'h0200_0014, 1'b0, 32'h0, rd); chk("burst_rb_crb", rd, 32'h0000_5678);

    // Read immediately after write to the same offset
    haddr = 32'h0200_0000; hwrite = 1'b1; htrans = 2'b10; @(negedge clk);
    hwrite = 1'b0; hwdata = 32'h0000_00E4; @(negedge clk);
    chk("fwd_mul0", hrdata, 32'h0000_00E4);
    htrans = 2'b00; @(negedge clk);
    chk("fwd_phases", {24'h0, wrcph, rdcph, wrph, rdph}, 32'h0000_00E4);
    haddr = 32'h0200_0014; hwrite = 1'b1; htrans = 2'b10; @(negedge clk);
    hwrite = 1'b0; hwdata = 32'hFFFF_1234; @(negedge clk);
    chk("fwd_crb_masked", hrdata, 32'h0000_1234);
    htrans = 2'b00; @(negedge clk);

    // Unselected and IDLE writes to MUL1 are ignored
    haddr = 32'h0200_0004; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b0; @(negedge clk);
    hsel = 1'b1; htrans = 2'b00; hwdata = 32'hFFFF_FFFF; @(negedge clk);
    hwrite = 1'b0; hwdata = 32'hEEEE_EEEE; @(negedge clk);
    chk("nosel_mul1_fields", {wtime, rtime, rtw, wtr}, 32'h2020_0808);
    xfer(32'h0200_0004, 1'b0, 32'h0, rd); chk("nosel_mul1_rb", rd, 32'h2020_0808);

    // Writes outside the window / to an unmapped offset
    for (int k = 0; k < 2; k++) begin
      haddr = (k == 0) ? 32'h0300_0000 : 32'h0200_0040;
      hwrite = 1'b1; htrans = 2'b10; @(negedge clk);
      htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h5A5A_5A5A;
`ifdef MC_CSR_ERRRESP_EN
      chk("err_c1_hready", 32'(hready), 32'h0);
      chk("err_c1_hresp", 32'(hresp), 32'h1);
      @(negedge clk);
      chk("err_c2_hready", 32'(hready), 32'h1);
      chk("err_c2_hresp", 32'(hresp), 32'h1);
`else
      chk("bad_wr_hready", 32'(hready), 32'h1);
      chk("bad_wr_hresp", 32'(hresp), 32'h0);
`endif
      @(negedge clk);
    end
    xfer(32'h0200_0000, 1'b0, 32'h0, rd); chk("bad_wr_mul0_kept", rd, 32'h0000_00E4);
    chk("bad_wr_tccd", 32'(tccd), 32'h00);
    xfer(32'h0300_0000, 1'b0, 32'h0, rd); chk("rd_out_of_window", rd, 32'h0);
    xfer(32'h0200_0040, 1'b0, 32'h0, rd); chk("rd_unmapped_40", rd, 32'h0);

    // Reset during the data phase of a CRB write
    haddr = 32'h0200_0014; hwrite = 1'b1; htrans = 2'b10; @(negedge clk);
    htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hAAAA_5555; rst = 1'b1; @(negedge clk);
    chk("midrst_grant", 32'(hgrant), 32'h0);
    rst = 1'b0; @(negedge clk);
    chk("midrst_rl_wl", {16'h0, wl, rl}, 32'h0000_080E);
    chk("midrst_grant_back", 32'(hgrant), 32'h1);
    xfer(32'h0200_0014, 1'b0, 32'h0, rd); chk("midrst_rb_crb", rd, 32'h0000_080E);
    xfer(32'h0200_0000, 1'b0, 32'h0, rd); chk("midrst_rb_mul0", rd, 32'h0410_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
